regfile_write_arbiter: RTL and testbench

// - Shares the single register-file write port between two writeback requesters:
//   req0 = ALU writeback, req1 = memory-load writeback.
// - Drives a one-hot load-enable vector and a common write-data bus into the

---
 rtl/regfile_write_arbiter_if.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle between the two writeback requesters and the register-file write arbiter.
// The arbiter side uses the slave modport; the requester/bank side uses master.
interface regfile_write_arbiter_if #(
  parameter int K      = 16,
  parameter int N_REGS = 8,
  parameter int ADDR_W = 3
);
  logic              stall;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [K-1:0]      req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [K-1:0]      req1_data;
  logic              req1_ready;
  logic [N_REGS-1:0] load;
  logic [K-1:0]      wdata;
  logic              err_addr;

  modport slave (
    input  stall,
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    output load, wdata, err_addr
  );

  modport master (
    output stall,
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    input  load, wdata, err_addr
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester (ALU / load) arbiter for the single register-file write port.
// Define RFWA_FIXED_PRIO_EN for fixed priority (req0 always wins); default is round-robin.
module regfile_write_arbiter #(
  parameter int K      = 16,
  parameter int N_REGS = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clock,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);

  localparam logic [ADDR_W:0] N_REGS_W = (ADDR_W+1)'(N_REGS);

  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [K-1:0]      sel_data;
  logic              in_range;
  logic [N_REGS-1:0] load_next;

`ifndef RFWA_FIXED_PRIO_EN
  typedef enum logic {
    LAST_REQ0 = 1'b0,
    LAST_REQ1 = 1'b1
  } last_grant_e;

  last_grant_e last_grant;
  last_grant_e last_grant_next;

  // Reset to "req1 last" so req0 wins the first conflict.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= LAST_REQ1;
    end else begin
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    last_grant_next = last_grant;
    if (grant0) begin
      last_grant_next = LAST_REQ0;
    end else if (grant1) begin
      last_grant_next = LAST_REQ1;
    end
  end
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset && !bus.stall) begin
`ifdef RFWA_FIXED_PRIO_EN
      grant0 = bus.req0_valid;
      grant1 = bus.req1_valid && !bus.req0_valid;
`else
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = (last_grant == LAST_REQ1);
        grant1 = (last_grant == LAST_REQ0);
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
`endif
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  assign xfer     = grant0 || grant1;
  assign sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
  assign sel_data = grant1 ? bus.req1_data : bus.req0_data;
  assign in_range = ({1'b0, sel_addr} < N_REGS_W);

  always_comb begin
    load_next = '0;
    for (int unsigned i = 0; i < N_REGS; i++) begin
      load_next[i] = xfer && in_range && (sel_addr == ADDR_W'(i));
    end
  end

  // Out-of-range writes still update wdata but raise err_addr instead of a load bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.load     <= '0;
      bus.wdata    <= '0;
      bus.err_addr <= 1'b0;
    end else begin
      bus.load     <= load_next;
      bus.err_addr <= xfer && !in_range;
      if (xfer) begin
        bus.wdata <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized self-checking bench for regfile_write_arbiter against a grant-rule reference model.
module tb_regfile_write_arbiter;
  localparam int K      = 16;
  localparam int N_REGS = 8;
  localparam int ADDR_W = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_write_arbiter_if #(.K(K), .N_REGS(N_REGS), .ADDR_W(ADDR_W)) bus ();

  regfile_write_arbiter #(.K(K), .N_REGS(N_REGS), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int                last_win = 1;
  logic [N_REGS-1:0] exp_load = '0;
  logic [K-1:0]      exp_wdata = '0;
  logic              exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
  endtask

  function automatic int pick();
    if (reset || bus.stall) return -1;
`ifdef RFWA_FIXED_PRIO_EN
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
`else
    if (bus.req0_valid && bus.req1_valid) return (last_win == 0) ? 1 : 0;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
`endif
  endfunction

  // One clock: check ready against the model, advance the model, check registered outputs.
  task automatic step(output int g);
    int a;
    logic [K-1:0] d;
    #1;
    g = pick();
    check("req0_ready", bus.req0_ready, g == 0);
    check("req1_ready", bus.req1_ready, g == 1);
    a = (g == 1) ? int'(bus.req1_addr) : int'(bus.req0_addr);
    d = (g == 1) ? bus.req1_data : bus.req0_data;
    @(posedge clock);
    if (reset) begin
      exp_load = '0; exp_wdata = '0; exp_err = 1'b0; last_win = 1;
    end else if (g >= 0) begin
      exp_load  = (a < N_REGS) ? N_REGS'(1 << a) : '0;
      exp_err   = (a >= N_REGS);
      exp_wdata = d;
      last_win  = g;
    end else begin
      exp_load = '0; exp_err = 1'b0;
    end
    @(negedge clock);
    check("load", bus.load, exp_load);
    check("wdata", bus.wdata, exp_wdata);
    check("err_addr", bus.err_addr, exp_err);
  endtask

  initial begin
    int g;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;

    step(g);
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd2; bus.req0_data = 16'h1111;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd5; bus.req1_data = 16'h2222;
    step(g);
    check("reset_load", bus.load, 0);
    check("reset_wdata", bus.wdata, 0);
    reset = 1'b0;

`ifndef RFWA_FIXED_PRIO_EN
    // Conflict right after reset: req0 first, then req1
    step(g);
    check("first_grant", g, 0);
    check("first_load", bus.load, 8'h04);
    check("first_wdata", bus.wdata, 16'h1111);
    bus.req0_valid = 1'b0;
    step(g);
    check("second_load", bus.load, 8'h20);
    check("second_wdata", bus.wdata, 16'h2222);
    bus.req1_valid = 1'b0;

    // Sustained conflict alternates
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd1; bus.req0_data = 16'hA000;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd6; bus.req1_data = 16'hB000;
    for (int i = 0; i < 6; i++) begin
      step(g);
      check("alternate", g, i % 2);
      check("load_nonzero", bus.load != 0, 1);
      if (g == 0) bus.req0_data = bus.req0_data + 16'd1;
      else        bus.req1_data = bus.req1_data + 16'd1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step(g);
    check("idle_load", bus.load, 0);

    // Stall holds req1 off
    bus.stall = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd3; bus.req1_data = 16'h3333;
    for (int i = 0; i < 3; i++) begin
      step(g);
      check("stall_ready1", bus.req1_ready, 0);
      check("stall_load", bus.load, 0);
    end
    bus.stall = 1'b0;
    step(g);
    check("unstall_grant", g, 1);
    check("unstall_load", bus.load, 8'h08);
    bus.req1_valid = 1'b0;

    // Range extremes
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd0; bus.req0_data = 16'h0F0F;
    step(g);
    check("addr0_load", bus.load, 8'h01);
    check("addr0_wdata", bus.wdata, 16'h0F0F);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_addr = 4'd7; bus.req1_data = 16'h7070;
    step(g);
    check("addr7_load", bus.load, 8'h80);
    check("addr7_wdata", bus.wdata, 16'h7070);
    bus.req1_valid = 1'b0;

    // Out-of-range address
    bus.req0_valid = 1'b1; bus.req0_addr = 4'd9; bus.req0_data = 16'h9999;
    step(g);
    check("oor_grant", g, 0);
    check("oor_err", bus.err_addr, 1);
    check("oor_load", bus.load, 0);
    bus.req0_valid = 1'b0;
    step(g);
    check("oor_err_pulse", bus.err_addr, 0);
`else
    // Fixed priority: req0 always wins a conflict
    for (int i = 0; i < 4; i++) begin
      step(g);
      check("fixed_grant", g, 0);
      check("fixed_ready1", bus.req1_ready, 0);
      bus.req0_data = bus.req0_data + 16'd1;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step(g);
`endif

    // Random traffic with stalls and occasional mid-operation reset
    for (int i = 0; i < 600; i++) begin
      if (!bus.req0_valid || g == 0) begin
        bus.req0_valid = ($urandom % 3) != 0;
        bus.req0_addr  = ADDR_W'($urandom_range(0, 11));
        bus.req0_data  = K'($urandom);
      end
      if (!bus.req1_valid || g == 1) begin
        bus.req1_valid = ($urandom % 3) != 0;
        bus.req1_addr  = ADDR_W'($urandom_range(0, 11));
        bus.req1_data  = K'($urandom);
      end
      bus.stall = ($urandom % 5) == 0;
      reset     = ($urandom % 40) == 0;
      step(g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
